keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad (Pmod KYPD on the Nexys A7 JA header) by driving one column at a time and reading the rows. It debounces the result over whole scans and emits a one-cycle pulse with the hex code of each new key press. It also keeps the last four entered digits as a 16-bit value. It is the input-side counterpart of the display multiplexer: that block drives digit selects and outputs segments, while this block drives columns and reads rows. Its value output feeds the counter/display datapath in place of the push-button increment path.

---
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-scan results and reports each new single-key press as a
// one-cycle pulse with its hex code, shifting that code into a 16-bit entry
// register.
//
// Build option: define KEYPAD_CLEAR_EN to make an accepted press of key C
// clear the entry register instead of shifting C in.
//
// Scan result encoding is {is_key, code}. NONE and MULTI both encode as
// 5'b0_0000, so they behave identically in the debounce and press logic.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int DW = $clog2(SCAN_DIV);
  // One extra count of headroom so the counter can actually hold DEBOUNCE_SCANS.
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] D_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] M_TARGET = MW'(DEBOUNCE_SCANS);

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [11:0]   scan_bits;
  logic [4:0]    prev_result, stable_result;
  logic [MW-1:0] match_cnt;

  logic          sample_now, scan_done;
  logic [15:0]   full_bits;
  logic [4:0]    result, stable_next;
  logic [MW-1:0] match_next;
  logic          press;

  // Bit index is col*4 + row.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h4;
      4'd2:    key_map = 4'h7;
      4'd3:    key_map = 4'h0;
      4'd4:    key_map = 4'h2;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h8;
      4'd7:    key_map = 4'hF;
      4'd8:    key_map = 4'h3;
      4'd9:    key_map = 4'h6;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hE;
      4'd12:   key_map = 4'hA;
      4'd13:   key_map = 4'hB;
      4'd14:   key_map = 4'hC;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign sample_now = (dwell == D_LAST);
  assign scan_done  = sample_now && (col == 2'd3);
  // Column 3 is still live on the rows during the completing sample cycle.
  assign full_bits  = {~row_sync, scan_bits};

  // Classify the 16 sampled bits of the scan as NONE, KEY(k) or MULTI.
  always_comb begin
    logic [4:0] cnt;
    logic [3:0] k;
    cnt = 5'd0;
    k   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (full_bits[i]) begin
        cnt = cnt + 5'd1;
        k   = key_map(4'(i));
      end
    end
    result = (cnt == 5'd1) ? {1'b1, k} : 5'b0_0000;
  end

  // Match counting and stable-result selection for the completing scan.
  always_comb begin
    if (result == prev_result)
      match_next = (match_cnt == M_TARGET) ? match_cnt : match_cnt + MW'(1);
    else
      match_next = MW'(1);
    stable_next = (match_next == M_TARGET) ? result : stable_result;
    press       = !stable_result[4] && stable_next[4];
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Column dwell timer, column rotation and per-column row capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dwell     <= '0;
      col       <= 2'd0;
      col_n     <= 4'b1110;
      scan_bits <= '0;
    end else if (sample_now) begin
      dwell <= '0;
      col   <= col + 2'd1;
      col_n <= {col_n[2:0], col_n[3]};
      case (col)
        2'd0:    scan_bits[3:0]  <= ~row_sync;
        2'd1:    scan_bits[7:4]  <= ~row_sync;
        2'd2:    scan_bits[11:8] <= ~row_sync;
        default: ;
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Debounce state, advanced once per completed scan.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_result   <= 5'b0;
      stable_result <= 5'b0;
      match_cnt     <= '0;
    end else if (scan_done) begin
      prev_result   <= result;
      match_cnt     <= match_next;
      stable_result <= stable_next;
    end
  end

  // Registered outputs: press pulse, key code, held flag and entry register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
      value     <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        key_held <= stable_next[4];
        if (press) begin
          key_valid <= 1'b1;
          key_code  <= stable_next[3:0];
`ifdef KEYPAD_CLEAR_EN
          if (stable_next[3:0] == 4'hC)
            value <= 16'h0000;
          else
            value <= {value[11:0], stable_next[3:0]};
`else
          value <= {value[11:0], stable_next[3:0]};
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV = 8, DEBOUNCE_SCANS = 2
// (one scan = 32 cycles). A row model pulls rows low for pressed keys on the
// currently driven column. Key masks use bit index col*4 + row.
module tb_keypad_scanner;

  localparam int SCAN = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] value;

  logic [15:0] keys;
  int          pulses;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [15:0] K1 = 16'h0001;  // r0 c0
  localparam logic [15:0] K2 = 16'h0010;  // r0 c1
  localparam logic [15:0] K3 = 16'h0100;  // r0 c2
  localparam logic [15:0] KA = 16'h1000;  // r0 c3
  localparam logic [15:0] K4 = 16'h0002;  // r1 c0
  localparam logic [15:0] K5 = 16'h0020;  // r1 c1
  localparam logic [15:0] K7 = 16'h0004;  // r2 c0
  localparam logic [15:0] KC = 16'h4000;  // r2 c3

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .value     (value)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[c*4 + r]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, counting key_valid high cycles at each falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  // Press for 4 scans, check code, release for 4 scans, check one pulse total.
  task automatic tap(input string tag, input logic [15:0] m, input logic [3:0] code);
    pulses = 0;
    keys = m;
    run(4 * SCAN);
    check({tag, " code"}, 16'(key_code), 16'(code));
    check({tag, " held"}, 16'(key_held), 16'd1);
    keys = '0;
    run(4 * SCAN);
    check({tag, " pulses"}, 16'(pulses), 16'd1);
    check({tag, " released"}, 16'(key_held), 16'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    keys    = '0;
    pulses  = 0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst col_n", 16'(col_n), 16'h000E);
    check("rst key_valid", 16'(key_valid), 16'd0);
    check("rst key_held", 16'(key_held), 16'd0);
    check("rst key_code", 16'(key_code), 16'd0);
    check("rst value", value, 16'h0000);

    // Column rotation after reset release
    reset_n = 1'b1;
    run(4);
    check("col0", 16'(col_n), 16'h000E);
    run(8);
    check("col1", 16'(col_n), 16'h000D);
    run(8);
    check("col2", 16'(col_n), 16'h000B);
    run(8);
    check("col3", 16'(col_n), 16'h0007);
    run(8);
    check("col wrap", 16'(col_n), 16'h000E);

    // Single key 5
    tap("key5", K5, 4'h5);
    check("key5 value", value, 16'h0005);

    // Sequence 1, 2, 3, A then 4 drops the top nibble
    tap("key1", K1, 4'h1);
    tap("key2", K2, 4'h2);
    tap("key3", K3, 4'h3);
    tap("keyA", KA, 4'hA);
    check("seq value", value, 16'h123A);
    tap("key4", K4, 4'h4);
    check("wrap value", value, 16'h23A4);

    // Bounce: key 7 present only on alternating scans
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? K7 : 16'h0000;
      run(SCAN);
      check("bounce held", 16'(key_held), 16'd0);
    end
    keys = '0;
    run(3 * SCAN);
    check("bounce pulses", 16'(pulses), 16'd0);
    check("bounce value", value, 16'h23A4);

    // Two keys together are ignored
    pulses = 0;
    keys = K1 | K2;
    run(4 * SCAN);
    check("multi pulses", 16'(pulses), 16'd0);
    check("multi held", 16'(key_held), 16'd0);
    // Release 2, keep 1: accepted as a press of 1
    keys = K1;
    run(4 * SCAN);
    check("multi->1 pulses", 16'(pulses), 16'd1);
    check("multi->1 code", 16'(key_code), 16'h1);
    check("multi->1 value", value, 16'h3A41);

    // Reset mid-scan with key 1 still held
    run(13);
    reset_n = 1'b0;
    run(3);
    check("midrst col_n", 16'(col_n), 16'h000E);
    check("midrst key_valid", 16'(key_valid), 16'd0);
    check("midrst key_code", 16'(key_code), 16'd0);
    check("midrst key_held", 16'(key_held), 16'd0);
    check("midrst value", value, 16'h0000);
    // Key held through reset is a fresh press once debounced
    pulses = 0;
    reset_n = 1'b1;
    run(4 * SCAN);
    check("post-rst pulses", 16'(pulses), 16'd1);
    check("post-rst code", 16'(key_code), 16'h1);
    check("post-rst value", value, 16'h0001);
    keys = '0;
    run(4 * SCAN);
    check("post-rst released", 16'(key_held), 16'd0);

    // Clear option
    tap("c1", K1, 4'h1);
    tap("c2", K2, 4'h2);
    tap("c3", K3, 4'h3);
    tap("cA", KA, 4'hA);
    check("pre-clear value", value, 16'h123A);
    tap("keyC", KC, 4'hC);
`ifdef KEYPAD_CLEAR_EN
    check("keyC value", value, 16'h0000);
`else
    check("keyC value", value, 16'h23AC);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
